serdes_cipher_deserializer: RTL

Receive-side stage directly downstream of the secure SerDes encryptor core. Samples the serial cipher bit stream and the core's `done` frame marker, reassembles bits MSB-first into bytes and decrypts each byte by XOR with an LFSR keystream seeded from the shared key. Plaintext bytes are buffered in a small FIFO and presented on a valid/ready interface to the host-side logic.

---
 rtl/serdes_pkg.sv | 34 +++
 rtl/serdes_byte_fifo.sv | 76 +++++++
 rtl/serdes_cipher_deserializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
//
// Shared definitions for the receive-side cipher deserializer:
//   rx_state_t        - frame reassembly state (IDLE, ACTIVE)
//   byte_t            - plaintext / ciphertext byte
//   LFSR_TAPS         - Fibonacci tap mask for bits 7,5,4,3
//   SEED_ZERO_DEFAULT - seed used in place of an all-zero key
//   lfsr_next()       - one keystream step
//   seed_of()         - key-to-seed mapping with zero-key substitution
// -----------------------------------------------------------------------------
package serdes_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

    typedef logic [7:0] byte_t;

    localparam byte_t LFSR_TAPS         = 8'hB8;
    localparam byte_t SEED_ZERO_DEFAULT = 8'hA5;

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    function automatic byte_t lfsr_next(input byte_t state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR never leaves zero, so a zero key is replaced.
    function automatic byte_t seed_of(input byte_t key, input byte_t zero_sub);
        return (key == 8'h00) ? zero_sub : key;
    endfunction

endpackage

// File: rtl/serdes_byte_fifo.sv
// -----------------------------------------------------------------------------
// serdes_byte_fifo
//
// Small first-word-fall-through byte FIFO. The head entry is visible on
// dout_o in the cycle after it is written; dout_o reads 8'h00 when empty.
// Pointers carry one extra MSB so full and empty are distinguished without
// a separate occupancy counter.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (pointers only)
//   push_i     - write din_i; accepted when not full, or when full and
//                pop_i frees the head in the same cycle
//   pop_i      - advance the head (ignored when empty)
//   din_i      - byte to write
//   dout_o     - head byte, 8'h00 when empty
//   empty_o    - no entries
//   full_o     - DEPTH entries
// -----------------------------------------------------------------------------
module serdes_byte_fifo
    import serdes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  logic  pop_i,
    input  byte_t din_i,
    output byte_t dout_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    byte_t       mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is only safe when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    // Storage has no reset: stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/serdes_cipher_deserializer.sv
// -----------------------------------------------------------------------------
// serdes_cipher_deserializer
//
// Collects the serial cipher stream MSB-first into bytes, decrypts each
// byte with an 8-bit LFSR keystream (one step per byte) seeded from key_i
// at frame start, and queues the plaintext in a byte FIFO drained through
// a valid/ready interface.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   cipher_bit_i   - serial cipher bit
//   bit_valid_i    - cipher_bit_i is sampled this cycle
//   done_i         - one-cycle frame-end marker
//   key_i          - keystream seed, sampled on the first bit of a frame
//   out_ready_i    - consumer accepts data_out_o this cycle
//   data_out_o     - FIFO head plaintext byte, 8'h00 when empty
//   data_valid_o   - FIFO non-empty
//   frame_end_o    - pulse in the cycle after a frame is closed
//   short_frame_o  - pulse with frame_end_o when a partial byte was dropped
//   overrun_o      - sticky: a completed byte was lost to a full FIFO
// -----------------------------------------------------------------------------
module serdes_cipher_deserializer
    import serdes_pkg::*;
#(
    parameter int    DEPTH     = 4,
    parameter byte_t SEED_ZERO = SEED_ZERO_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cipher_bit_i,
    input  logic       bit_valid_i,
    input  logic       done_i,
    input  logic [7:0] key_i,
    input  logic       out_ready_i,
    output logic [7:0] data_out_o,
    output logic       data_valid_o,
    output logic       frame_end_o,
    output logic       short_frame_o,
    output logic       overrun_o
);

    rx_state_t   state_q;
    byte_t       sh_q;
    logic [2:0]  cnt_q;
    byte_t       lfsr_q;
    logic        frame_end_q;
    logic        short_frame_q;
    logic        overrun_q;

    byte_t       sh_d;
    logic [2:0]  cnt_d;
    logic        byte_done;
    logic        frame_close;
    byte_t       plain_byte;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;
    byte_t       fifo_dout;

    // Shift register and bit count as they stand once this cycle's bit is
    // taken in. sh_q is held at zero while idle, so the first bit of a
    // frame lands in bit 0 and reaches bit 7 after eight shifts.
    assign sh_d  = {sh_q[6:0], cipher_bit_i};
    assign cnt_d = bit_valid_i ? (cnt_q + 3'd1) : cnt_q;

    // cnt_q is always zero in IDLE, so only ACTIVE can complete a byte.
    assign byte_done  = (state_q == ACTIVE) && bit_valid_i && (cnt_q == 3'd7);
    assign plain_byte = sh_d ^ lfsr_q;

    // The bit in the done cycle is taken first; a first bit arriving with
    // done therefore opens and closes a one-bit frame.
    assign frame_close = done_i && ((state_q == ACTIVE) || bit_valid_i);

    assign fifo_push = byte_done;
    assign fifo_pop  = data_valid_o && out_ready_i;

    serdes_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (plain_byte),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            cnt_q         <= '0;
            lfsr_q        <= '0;
            frame_end_q   <= 1'b0;
            short_frame_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_end_q   <= frame_close;
            short_frame_q <= frame_close && (cnt_d != 3'd0);

            // The FIFO drops the byte itself; only the flag is kept here.
            if (fifo_push && fifo_full && !fifo_pop) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (bit_valid_i) begin
                        lfsr_q  <= seed_of(key_i, SEED_ZERO);
                        sh_q    <= {7'b0, cipher_bit_i};
                        cnt_q   <= 3'd1;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bit_valid_i) begin
                        sh_q  <= sh_d;
                        cnt_q <= cnt_d;
                        // Keystream advances per byte, not per bit.
                        if (cnt_q == 3'd7) begin
                            lfsr_q <= lfsr_next(lfsr_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Closing overrides the bit update above; any partial byte is
            // discarded and the next frame starts from a clean shifter.
            if (frame_close) begin
                state_q <= IDLE;
                sh_q    <= '0;
                cnt_q   <= '0;
            end
        end
    end

    assign data_out_o    = fifo_dout;
    assign data_valid_o  = !fifo_empty;
    assign frame_end_o   = frame_end_q;
    assign short_frame_o = short_frame_q;
    assign overrun_o     = overrun_q;

endmodule
